// File: rtl/fifo_arb_pkg.sv
// Shared widths, FSM encoding and output payload for the FIFO pop arbiter.
package fifo_arb_pkg;

    localparam int unsigned N_FIFOS = 4;
    localparam int unsigned DATA_W  = 6;
    localparam int unsigned IDX_W   = $clog2(N_FIFOS);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        STALL  = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } out_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand_c;

    // N is a power of two, so the IW-bit add wraps the search naturally
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand_c      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_c = ptr_i + IW'(k);
            if (!any_o && req_i[cand_c]) begin
                any_o            = 1'b1;
                grant_idx_o      = cand_c;
                grant_o[cand_c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Round-robin read side of the FIFO bank: pops upstream FIFOs, tags and registers the words.
// Define FIFO_ARB_PRIO0_EN to give FIFO 0 strict priority over the round-robin search.
module fifo_pop_arbiter
    import fifo_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_FIFOS-1:0]          fifo_empty,
    input  logic [N_FIFOS*DATA_W-1:0]   fifo_data,
    input  logic                        ds_almost_full,
    input  logic                        ds_full,
    output logic [N_FIFOS-1:0]          fifo_pop,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    output logic [IDX_W-1:0]            dest_out,
    output logic                        error
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_FIFOS-1:0] pop_q;
    logic               pend_q;
    logic [IDX_W-1:0]   pend_idx_q;
    out_word_t          out_q;
    logic               valid_q;
    logic               error_q;

    logic [N_FIFOS-1:0] elig_c;
    logic [N_FIFOS-1:0] rr_grant_c;
    logic [IDX_W-1:0]   rr_idx_c;
    logic               any_elig_c;
    logic               any_pending_c;
    logic [N_FIFOS-1:0] sel_oh_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic               sel_upd_c;

    // A FIFO popped last cycle is skipped: its registered empty flag has not caught up yet
    assign elig_c        = ~fifo_empty & ~pop_q;
    assign any_pending_c = |(~fifo_empty);

    rr_arbiter #(
        .N  (N_FIFOS),
        .IW (IDX_W)
    ) u_rr (
        .req_i       (elig_c),
        .ptr_i       (rr_ptr_q),
        .grant_o     (rr_grant_c),
        .grant_idx_o (rr_idx_c),
        .any_o       (any_elig_c)
    );

    always_comb begin
        sel_oh_c  = rr_grant_c;
        sel_idx_c = rr_idx_c;
        sel_upd_c = 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
        if (elig_c[0]) begin
            sel_oh_c  = N_FIFOS'(1);
            sel_idx_c = '0;
            sel_upd_c = 1'b0;
        end
`else
        sel_upd_c = 1'b1;
`endif
    end

    // ACTIVE rides through cooldown-only cycles so a lone FIFO pops every other cycle
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        fifo_pop = '0;
        case (state_q)
            IDLE: begin
                if (any_elig_c && !ds_almost_full) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (ds_almost_full) begin
                    state_d = STALL;
                end else if (!any_pending_c) begin
                    state_d = IDLE;
                end else if (any_elig_c) begin
                    fifo_pop = sel_oh_c;
                    if (sel_upd_c) rr_ptr_d = sel_idx_c + IDX_W'(1);
                end
            end
            STALL: begin
                if (!ds_almost_full) state_d = any_elig_c ? ACTIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            pop_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pop_q      <= fifo_pop;
            pend_q     <= |fifo_pop;
            pend_idx_q <= sel_idx_c;
            valid_q    <= pend_q;
            error_q    <= valid_q && ds_full;
            if (pend_q) begin
                out_q.dest <= pend_idx_q;
                out_q.data <= fifo_data[32'(pend_idx_q) * DATA_W +: DATA_W];
            end
        end
    end

    assign data_out  = out_q.data;
    assign dest_out  = out_q.dest;
    assign valid_out = valid_q;
    assign error     = error_q;

endmodule
